// File: rtl/switch_debounce_if.sv
// Switch port bundle between the board-switch debouncer and its consumers.
// master: the side driving raw switch levels and the CPU read strobe.
// slave : the debouncer itself.
interface switch_debounce_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sw_raw;
   logic             IORead;
   logic [WIDTH-1:0] io_read_data;
   logic             sw_change;
   logic             sw_event;

   modport master (
      output sw_raw,
      output IORead,
      input  io_read_data,
      input  sw_change,
      input  sw_event
   );

   modport slave (
      input  sw_raw,
      input  IORead,
      output io_read_data,
      output sw_change,
      output sw_event
   );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit switch debouncer.
// Each raw switch bit is synchronised with two flops, then a per-bit counter
// must observe DEBOUNCE_CNT consecutive samples that disagree with the stable
// level before the stable level (io_read_data) follows.
// Optional feature macro SW_EVENT_EN: compiles in the registered sw_change
// pulse and the sticky sw_event flag (cleared by IORead, set wins). Without
// it both outputs are tied to 0 and IORead is ignored.
module switch_debounce #(
   parameter int WIDTH        = 8,
   parameter int DEBOUNCE_CNT = 1000000,
   parameter int CNT_W        = 20
) (
   input  logic             clk,
   input  logic             rst,
   switch_debounce_if.slave bus
);

   // Last counter value before the stable level is allowed to follow.
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] stable_r;
   logic [WIDTH-1:0] stable_nxt_s;
   logic [WIDTH-1:0] update_s;
   logic [CNT_W-1:0] cnt_r     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

   // Two-flop synchroniser for the asynchronous switch levels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= bus.sw_raw;
         sync2_r <= sync1_r;
      end
   end

   // Per-bit debounce decision: clear on agreement, count on disagreement,
   // adopt the new level once the counter has reached its terminal value.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt_s[i]    = '0;
         stable_nxt_s[i] = stable_r[i];
         update_s[i]     = 1'b0;
         if (sync2_r[i] == stable_r[i]) begin
            cnt_nxt_s[i] = '0;
         end else if (cnt_r[i] < CNT_TERM) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
         end else begin
            stable_nxt_s[i] = sync2_r[i];
            update_s[i]     = 1'b1;
            cnt_nxt_s[i]    = '0;
         end
      end
   end

   // Counter and stable-level registers; reset discards any partial count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_r <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         stable_r <= stable_nxt_s;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   assign bus.io_read_data = stable_r;

`ifdef SW_EVENT_EN
   logic change_r;
   logic event_r;

   // Change pulse registered on the same edge as the stable update; sticky
   // event flag set by that pulse, cleared by a CPU read, set has priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         change_r <= 1'b0;
         event_r  <= 1'b0;
      end else begin
         change_r <= |update_s;
         if (change_r) begin
            event_r <= 1'b1;
         end else if (bus.IORead) begin
            event_r <= 1'b0;
         end else begin
            event_r <= event_r;
         end
      end
   end

   assign bus.sw_change = change_r;
   assign bus.sw_event  = event_r;
`else
   logic unused_io_read_s;
   logic unused_update_s;

   assign bus.sw_change     = 1'b0;
   assign bus.sw_event      = 1'b0;
   assign unused_io_read_s  = bus.IORead;
   assign unused_update_s   = |update_s;
`endif

endmodule
